mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Sequences and shares the single byte-wide main-memory port between instruction fetch (IF) and the load/store unit (LSU) of the CPU. It accepts word-level requests, serialises them into little-endian byte accesses on a RAM with one-cycle read latency, assembles and sign- or zero-extends load data, and returns one-cycle completion pulses. LSU has fixed priority over IF. An IF flush aborts an in-flight fetch without disturbing LSU traffic.

## Interface
- ADDR_W, 32, byte address width; all address arithmetic wraps modulo 2^ADDR_W.

- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request. Level signal, held with stable operands until if_done.
- if_addr  in  ADDR_W  fetch address (any alignment).
- if_flush  in  1  aborts an IF transaction that is in flight.
- if_done  out  1  one-cycle pulse; if_inst/if_pc valid in that cycle.
- if_inst  out  32  fetched word, little-endian.
- if_pc  out  ADDR_W  address of the completed fetch.
- lsu_req  in  1  load/store request. Level signal, held until lsu_done.
- lsu_we  in  1  1 = store, 0 = load.
- lsu_funct3  in  3  RISC-V size code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- lsu_addr  in  ADDR_W  byte address.
- lsu_wdata  in  32  store data; low bytes are used.
- lsu_done  out  1  one-cycle completion pulse.
- lsu_rdata  out  32  extended load result, valid with lsu_done; 0 for stores.
- busy  out  1  high in every state except IDLE.
- ram_din  in  8  byte read from RAM; corresponds to the ram_addr of the previous cycle.
- ram_addr  out  ADDR_W  RAM byte address.
- ram_wr  out  1  RAM write strobe.
- ram_dout  out  8  RAM write byte.

## Operation
- States: IDLE, XFER, WAIT, DONE.
- IDLE:
  - lsu_req wins over if_req.
  - Latch owner, base address, byte count n (B/BU = 1, H/HU = 2, W = 4, IF = 4), we, funct3 and store data.
  - Go to XFER.
- Invalid lsu_funct3 (011, 110, 111), or a store with BU/HU:
  - Go directly to DONE with no RAM access.
  - lsu_rdata = 0.
- XFER:
  - Runs n cycles; on cycle i (i = 0..n-1), ram_addr = base + i.
  - Stores: ram_wr = 1 and ram_dout = wdata byte i.
  - Reads: each ram_din byte is shifted into the assembly register one cycle after its address, landing in byte lane i.
  - After cycle n-1: stores go to DONE, reads go to WAIT.
- WAIT: captures the final read byte, then goes to DONE.
- DONE:
  - Pulse the owner's done.
  - LSU loads: lsu_rdata sign-extended for B/H, zero-extended for BU/HU, raw for W.
  - IF: if_inst = assembled word, if_pc = base.
  - Requests are ignored in this cycle (turnaround, so a held req is not double-serviced).
  - Go to IDLE.
- Flush:
  - Applies when if_flush = 1 while owner = IF and state is XFER or WAIT.
  - Next state is IDLE, with no if_done.
  - Flush in IDLE: an if_req in the same cycle is not granted.
  - Flush in IF's DONE: if_done still pulses; the client discards it.
  - Flush never affects LSU transactions.
- Idle outputs: ram_wr = 0, ram_addr = 0, ram_dout = 0.

## Timing
- Request seen in IDLE at cycle 0; XFER occupies cycles 1..n.
- Latencies from cycle 0:
  - Load or fetch: done at cycle n+2 (LW/IF: 6, LH: 4, LB: 3).
  - Store: done at cycle n+1 (SW: 5, SB: 2).
  - Invalid request: done at cycle 1.
- Earliest next grant: the cycle after DONE.
- All outputs are registered.
- Reset values: if_done 0, if_inst 0, if_pc 0, lsu_done 0, lsu_rdata 0, busy 0, ram_addr 0, ram_wr 0, ram_dout 0; state IDLE.
- Reset mid-transaction: transaction abandoned with no done pulse; ram_wr is 0 from the next edge.
- Address wrap: base 0xFFFFFFFE with LW accesses FE, FF, 00, 01.

## Structure
- Package mem_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum IDLE/XFER/WAIT/DONE.
  - Owner enum OWN_IF/OWN_LSU.
- Sub-module load_extend: combinational; inputs 32-bit assembled word and funct3, output extended 32-bit result. Instantiated once.

## Test plan
- LW at 0x100 with RAM bytes 11,22,33,44 -> ram_addr 100..103 in cycles 1-4, lsu_done at cycle 6, lsu_rdata 0x44332211.
- LB at 0x20 holding 0x80 -> lsu_rdata 0xFFFFFF80; LBU at the same address -> 0x00000080; LHU at 0x20 holding 80,FF -> 0x0000FF80.
- SH of 0xDEADBEEF at 0x40 -> ram_wr high in cycles 1-2 with EF@40 then BE@41, lsu_done at cycle 3, byte 0x42 untouched.
- if_req and lsu_req in the same cycle, both held -> LSU completes first; IF grant in the cycle after LSU's DONE; if_done with correct if_pc.
- IF fetch at 0x0, if_flush in cycle 3 -> IDLE at cycle 4, no if_done; a following if_req at 0x8 completes normally.
- rst in cycle 2 of an SW -> ram_wr 0 and busy 0 from the next edge, no lsu_done; invalid funct3 011 -> lsu_done at cycle 1, rdata 0, ram_wr never high.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants and types for the byte-serial memory arbiter.
// Covers RISC-V load/store size codes, arbiter FSM states and bus owner.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, XFER, WAIT, DONE} state_t;
  typedef enum logic {OWN_IF, OWN_LSU} owner_t;

  // Index of the last byte accessed (byte count minus one).
  function automatic logic [1:0] last_idx(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: last_idx = 2'd0;
      F3_H, F3_HU: last_idx = 2'd1;
      default:     last_idx = 2'd3;
    endcase
  endfunction

  // Unsigned sizes have no meaning for stores.
  function automatic logic f3_valid(input logic we, input logic [2:0] f3);
    case (f3)
      F3_B, F3_H, F3_W: f3_valid = 1'b1;
      F3_BU, F3_HU:     f3_valid = !we;
      default:          f3_valid = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Sign- or zero-extends an assembled little-endian load word by size code.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  always_comb begin
    case (funct3)
      F3_B:    result = {{24{word[7]}}, word[7:0]};
      F3_H:    result = {{16{word[15]}}, word[15:0]};
      F3_BU:   result = {24'd0, word[7:0]};
      F3_HU:   result = {16'd0, word[15:0]};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one byte-wide, one-cycle-latency RAM port between instruction fetch
// and the LSU; serialises word requests into little-endian byte accesses.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_done,
  output logic [31:0]       if_inst,
  output logic [ADDR_W-1:0] if_pc,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [2:0]        lsu_funct3,
  input  logic [ADDR_W-1:0] lsu_addr,
  input  logic [31:0]       lsu_wdata,
  output logic              lsu_done,
  output logic [31:0]       lsu_rdata,
  output logic              busy,
  input  logic [7:0]        ram_din,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic [7:0]        ram_dout
);

  state_t            state_reg, state_next;
  owner_t            owner_reg, owner_next;
  logic [ADDR_W-1:0] base_reg, base_next;
  logic [1:0]        last_reg, last_next;
  logic [1:0]        cnt_reg, cnt_next;
  logic              we_reg, we_next;
  logic [2:0]        f3_reg, f3_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       asm_reg, asm_next;
  logic              if_done_reg, if_done_next;
  logic [31:0]       if_inst_reg, if_inst_next;
  logic [ADDR_W-1:0] if_pc_reg, if_pc_next;
  logic              lsu_done_reg, lsu_done_next;
  logic [31:0]       lsu_rdata_reg, lsu_rdata_next;
  logic              busy_reg, busy_next;
  logic [ADDR_W-1:0] ram_addr_reg, ram_addr_next;
  logic              ram_wr_reg, ram_wr_next;
  logic [7:0]        ram_dout_reg, ram_dout_next;

  logic [1:0]  cap_idx;
  logic [1:0]  cnt_inc;
  logic [31:0] merged;
  logic [31:0] extended;
  logic        flush_hit;

  // The byte on ram_din belongs to the address issued one cycle earlier.
  always_comb begin
    cap_idx = (state_reg == WAIT) ? last_reg : cnt_reg - 2'd1;
    merged  = asm_reg;
    merged[{cap_idx, 3'b000} +: 8] = ram_din;
  end

  load_extend u_load_extend (
    .word   (merged),
    .funct3 (f3_reg),
    .result (extended)
  );

  assign cnt_inc   = cnt_reg + 2'd1;
  assign flush_hit = if_flush && (owner_reg == OWN_IF);

  always_comb begin
    state_next     = state_reg;
    owner_next     = owner_reg;
    base_next      = base_reg;
    last_next      = last_reg;
    cnt_next       = cnt_reg;
    we_next        = we_reg;
    f3_next        = f3_reg;
    wdata_next     = wdata_reg;
    asm_next       = asm_reg;
    if_done_next   = 1'b0;
    if_inst_next   = if_inst_reg;
    if_pc_next     = if_pc_reg;
    lsu_done_next  = 1'b0;
    lsu_rdata_next = lsu_rdata_reg;
    ram_addr_next  = '0;
    ram_wr_next    = 1'b0;
    ram_dout_next  = 8'd0;

    case (state_reg)
      IDLE: begin
        if (lsu_req) begin
          owner_next = OWN_LSU;
          base_next  = lsu_addr;
          last_next  = last_idx(lsu_funct3);
          cnt_next   = 2'd0;
          we_next    = lsu_we;
          f3_next    = lsu_funct3;
          wdata_next = lsu_wdata;
          asm_next   = 32'd0;
          if (!f3_valid(lsu_we, lsu_funct3)) begin
            state_next     = DONE;
            lsu_done_next  = 1'b1;
            lsu_rdata_next = 32'd0;
          end else begin
            state_next    = XFER;
            ram_addr_next = lsu_addr;
            ram_wr_next   = lsu_we;
            ram_dout_next = lsu_wdata[7:0];
          end
        end else if (if_req && !if_flush) begin
          owner_next    = OWN_IF;
          base_next     = if_addr;
          last_next     = 2'd3;
          cnt_next      = 2'd0;
          we_next       = 1'b0;
          f3_next       = F3_W;
          asm_next      = 32'd0;
          state_next    = XFER;
          ram_addr_next = if_addr;
        end
      end
      XFER: begin
        if (flush_hit) begin
          state_next = IDLE;
        end else begin
          if (cnt_reg != 2'd0 && !we_reg)
            asm_next = merged;
          if (cnt_reg == last_reg) begin
            if (we_reg) begin
              state_next     = DONE;
              lsu_done_next  = 1'b1;
              lsu_rdata_next = 32'd0;
            end else begin
              state_next = WAIT;
            end
          end else begin
            cnt_next      = cnt_inc;
            ram_addr_next = base_reg + ADDR_W'(cnt_inc);
            ram_wr_next   = we_reg;
            ram_dout_next = wdata_reg[{cnt_inc, 3'b000} +: 8];
          end
        end
      end
      WAIT: begin
        if (flush_hit) begin
          state_next = IDLE;
        end else begin
          asm_next   = merged;
          state_next = DONE;
          if (owner_reg == OWN_IF) begin
            if_done_next = 1'b1;
            if_inst_next = merged;
            if_pc_next   = base_reg;
          end else begin
            lsu_done_next  = 1'b1;
            lsu_rdata_next = extended;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_reg     <= OWN_IF;
      base_reg      <= '0;
      last_reg      <= 2'd0;
      cnt_reg       <= 2'd0;
      we_reg        <= 1'b0;
      f3_reg        <= 3'd0;
      wdata_reg     <= 32'd0;
      asm_reg       <= 32'd0;
      if_done_reg   <= 1'b0;
      if_inst_reg   <= 32'd0;
      if_pc_reg     <= '0;
      lsu_done_reg  <= 1'b0;
      lsu_rdata_reg <= 32'd0;
      busy_reg      <= 1'b0;
      ram_addr_reg  <= '0;
      ram_wr_reg    <= 1'b0;
      ram_dout_reg  <= 8'd0;
    end else begin
      state_reg     <= state_next;
      owner_reg     <= owner_next;
      base_reg      <= base_next;
      last_reg      <= last_next;
      cnt_reg       <= cnt_next;
      we_reg        <= we_next;
      f3_reg        <= f3_next;
      wdata_reg     <= wdata_next;
      asm_reg       <= asm_next;
      if_done_reg   <= if_done_next;
      if_inst_reg   <= if_inst_next;
      if_pc_reg     <= if_pc_next;
      lsu_done_reg  <= lsu_done_next;
      lsu_rdata_reg <= lsu_rdata_next;
      busy_reg      <= busy_next;
      ram_addr_reg  <= ram_addr_next;
      ram_wr_reg    <= ram_wr_next;
      ram_dout_reg  <= ram_dout_next;
    end
  end

  assign if_done   = if_done_reg;
  assign if_inst   = if_inst_reg;
  assign if_pc     = if_pc_reg;
  assign lsu_done  = lsu_done_reg;
  assign lsu_rdata = lsu_rdata_reg;
  assign busy      = busy_reg;
  assign ram_addr  = ram_addr_reg;
  assign ram_wr    = ram_wr_reg;
  assign ram_dout  = ram_dout_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with a 1 KiB behavioural RAM
// (registered read, indexed by the low address bits).
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_flush, if_done;
  logic [31:0] if_addr, if_inst, if_pc;
  logic        lsu_req, lsu_we, lsu_done, busy;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [7:0]  ram_din, ram_dout;
  logic [31:0] ram_addr;
  logic        ram_wr;

  logic [7:0] mem [0:1023];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr) mem[ram_addr[9:0]] <= ram_dout;
    ram_din <= mem[ram_addr[9:0]];
  end

  mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_done(if_done), .if_inst(if_inst), .if_pc(if_pc),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_funct3(lsu_funct3),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .busy(busy),
    .ram_din(ram_din), .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_dout(ram_dout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one LSU request in the current (IDLE) cycle; n = bytes accessed,
  // lat = cycle of lsu_done counted from the request cycle.
  task automatic run_lsu(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input int n, input int lat, input logic [31:0] exp);
    lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_addr = addr; lsu_wdata = wd;
    for (int c = 1; c <= lat; c++) begin
      tick();
      check({tag, "_done"}, 32'(lsu_done), 32'(c == lat));
      check({tag, "_wr"}, 32'(ram_wr), 32'(we && c <= n));
      if (c <= n) check({tag, "_addr"}, ram_addr, addr + 32'(c - 1));
      if (c == lat) check({tag, "_rdata"}, lsu_rdata, exp);
    end
    lsu_req = 1'b0;
    tick();
    $display("txn %s we=%0b f3=%0d addr=%h rdata=%h", tag, we, f3, addr, lsu_rdata);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
    lsu_req = 0; lsu_we = 0; lsu_funct3 = 0; lsu_addr = 0; lsu_wdata = 0;
    tick(); tick();
    check("rst_busy", 32'(busy), 0);
    check("rst_if_done", 32'(if_done), 0);
    check("rst_lsu_done", 32'(lsu_done), 0);
    check("rst_ram_wr", 32'(ram_wr), 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_dout", 32'(ram_dout), 0);
    check("rst_lsu_rdata", lsu_rdata, 0);
    check("rst_if_inst", if_inst, 0);
    check("rst_if_pc", if_pc, 0);
    rst = 1'b0;
    tick();

    mem[10'h100] = 8'h11; mem[10'h101] = 8'h22; mem[10'h102] = 8'h33; mem[10'h103] = 8'h44;
    mem[10'h020] = 8'h80; mem[10'h021] = 8'hFF;
    mem[10'h042] = 8'h5A;
    mem[10'h200] = 8'h01; mem[10'h201] = 8'h02; mem[10'h202] = 8'h03; mem[10'h203] = 8'h04;
    mem[10'h000] = 8'hAA; mem[10'h001] = 8'hBB; mem[10'h002] = 8'hCC; mem[10'h003] = 8'hDD;
    mem[10'h008] = 8'h13; mem[10'h009] = 8'h05; mem[10'h00A] = 8'h10; mem[10'h00B] = 8'h00;

    run_lsu("lw",  0, 3'b010, 32'h100, 0, 4, 6, 32'h44332211);
    run_lsu("lb",  0, 3'b000, 32'h20,  0, 1, 3, 32'hFFFFFF80);
    run_lsu("lbu", 0, 3'b100, 32'h20,  0, 1, 3, 32'h00000080);
    run_lsu("lhu", 0, 3'b101, 32'h20,  0, 2, 4, 32'h0000FF80);
    run_lsu("lh",  0, 3'b001, 32'h20,  0, 2, 4, 32'hFFFFFF80);
    run_lsu("sh",  1, 3'b001, 32'h40,  32'hDEADBEEF, 2, 3, 32'h0);
    check("sh_b40", 32'(mem[10'h040]), 32'hEF);
    check("sh_b41", 32'(mem[10'h041]), 32'hBE);
    check("sh_b42", 32'(mem[10'h042]), 32'h5A);
    run_lsu("sb",  1, 3'b000, 32'h50,  32'h000000A7, 1, 2, 32'h0);
    check("sb_b50", 32'(mem[10'h050]), 32'hA7);
    run_lsu("sw_wrap", 1, 3'b010, 32'hFFFFFFFE, 32'hCAFEF00D, 4, 5, 32'h0);
    run_lsu("lw_wrap", 0, 3'b010, 32'hFFFFFFFE, 0, 4, 6, 32'hCAFEF00D);
    run_lsu("inv011", 0, 3'b011, 32'h100, 0, 0, 1, 32'h0);
    run_lsu("inv_sbu", 1, 3'b100, 32'h60, 32'h12345678, 0, 1, 32'h0);
    check("inv_sbu_mem", 32'(mem[10'h060]), 32'h00);

    // Simultaneous requests: LSU first, IF granted right after LSU's DONE.
    lsu_req = 1; lsu_we = 0; lsu_funct3 = 3'b010; lsu_addr = 32'h100;
    if_req = 1; if_addr = 32'h200;
    for (int c = 1; c <= 13; c++) begin
      tick();
      check("arb_lsu_done", 32'(lsu_done), 32'(c == 6));
      check("arb_if_done", 32'(if_done), 32'(c == 13));
      if (c == 6) begin
        check("arb_lsu_rdata", lsu_rdata, 32'h44332211);
        lsu_req = 0;
      end
      if (c == 8) check("arb_if_addr", ram_addr, 32'h200);
      if (c == 13) begin
        check("arb_if_inst", if_inst, 32'h04030201);
        check("arb_if_pc", if_pc, 32'h200);
        if_req = 0;
      end
    end
    tick();
    $display("txn arb lsu_rdata=%h if_inst=%h if_pc=%h", lsu_rdata, if_inst, if_pc);

    // Fetch flushed in cycle 3, then a fresh fetch at 0x8.
    if_req = 1; if_addr = 32'h0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("flush_if_done", 32'(if_done), 0);
      if (c == 3) begin
        if_flush = 1; if_req = 0; if_addr = 32'h8;
      end
    end
    check("flush_busy", 32'(busy), 0);
    if_flush = 0; if_req = 1;
    for (int c = 1; c <= 6; c++) begin
      tick();
      check("refetch_done", 32'(if_done), 32'(c == 6));
      if (c == 6) begin
        check("refetch_inst", if_inst, 32'h00100513);
        check("refetch_pc", if_pc, 32'h8);
      end
    end
    if_req = 0;
    tick();
    $display("txn flush_refetch if_inst=%h if_pc=%h", if_inst, if_pc);

    // Reset in cycle 2 of a store.
    lsu_req = 1; lsu_we = 1; lsu_funct3 = 3'b010; lsu_addr = 32'h300; lsu_wdata = 32'h11223344;
    tick(); tick();
    check("rstmid_wr_before", 32'(ram_wr), 1);
    rst = 1;
    tick();
    check("rstmid_wr", 32'(ram_wr), 0);
    check("rstmid_busy", 32'(busy), 0);
    rst = 0; lsu_req = 0;
    for (int c = 0; c < 4; c++) begin
      check("rstmid_no_done", 32'(lsu_done), 0);
      tick();
    end
    $display("txn reset_mid_store busy=%0b ram_wr=%0b", busy, ram_wr);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
